// File: rtl/riego_pump_scheduler.sv
`default_nettype none
// ============================================================================
// riego_pump_scheduler : round-robin pump/valve sequencer for N irrigation
//                        zones with level-fault latch.
// Revision: 1.0
// ============================================================================
module riego_pump_scheduler #(
   parameter int N_ZONES      = 4,
   parameter int OPEN_CYCLES  = 4,
   parameter int SLOT_CYCLES  = 1000,
   parameter int CLOSE_CYCLES = 4,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_ZONES-1:0]         req_i,
   input  logic                       level_ok_i,
   input  logic                       fault_clr_i,
   output logic [N_ZONES-1:0]         valve_o,
   output logic                       pump_on_o,
   output logic [$clog2(N_ZONES)-1:0] grant_id_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       error_o
);

   localparam int GW = $clog2(N_ZONES);

   localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_OPEN  = 3'd1,
      S_RUN   = 3'd2,
      S_CLOSE = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [GW-1:0]      ptr_q, ptr_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [N_ZONES-1:0] valve_q, valve_d;
   logic               pump_q, pump_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;

   logic [GW-1:0]      w_sel;
   logic               w_found;
   logic [CNT_W-1:0]   w_timer_inc;

   function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_ZONES) s = s - N_ZONES;
      return GW'(s);
   endfunction

   // First requester at or above the rr pointer, wrapping around.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N_ZONES; k++) begin
         if (!w_found && req_i[wrap_add(ptr_q, k)]) begin
            w_found = 1'b1;
            w_sel   = wrap_add(ptr_q, k);
         end
      end
   end

   assign w_timer_inc = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      timer_d = w_timer_inc;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      valve_d = valve_q;
      pump_d  = pump_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = error_q;

      // A low tank level beats every other transition.
      if (state_q != S_FAULT && !level_ok_i) begin
         state_d = S_FAULT;
         timer_d = '0;
         valve_d = '0;
         pump_d  = 1'b0;
         busy_d  = 1'b0;
         error_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_found) begin
                  state_d = S_OPEN;
                  timer_d = '0;
                  grant_d = w_sel;
                  valve_d = N_ZONES'(1) << w_sel;
                  busy_d  = 1'b1;
               end
            end
            S_OPEN: begin
               if (timer_q == OPEN_LAST) begin
                  state_d = S_RUN;
                  timer_d = '0;
                  pump_d  = 1'b1;
               end
            end
            S_RUN: begin
               if (timer_q == SLOT_LAST || !req_i[grant_q]) begin
                  state_d = S_CLOSE;
                  timer_d = '0;
                  pump_d  = 1'b0;
               end
            end
            S_CLOSE: begin
               if (timer_q == CLOSE_LAST) begin
                  state_d = S_IDLE;
                  timer_d = '0;
                  valve_d = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  ptr_d   = (grant_q == GW'(N_ZONES - 1)) ? '0 : grant_q + GW'(1);
               end
            end
            S_FAULT: begin
               if (fault_clr_i && level_ok_i) begin
                  state_d = S_IDLE;
                  timer_d = '0;
                  error_d = 1'b0;
               end
            end
            default: begin
               state_d = S_IDLE;
               timer_d = '0;
               valve_d = '0;
               pump_d  = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         valve_q <= '0;
         pump_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         valve_q <= valve_d;
         pump_q  <= pump_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign valve_o    = valve_q;
   assign pump_on_o  = pump_q;
   assign grant_id_o = grant_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_riego_pump_scheduler.sv
`default_nettype none
// ============================================================================
// tb_riego_pump_scheduler : vector table, corner sequences and randomized
//                           run against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_riego_pump_scheduler;

   localparam int N     = 4;
   localparam int OPEN  = 2;
   localparam int SLOT  = 8;
   localparam int CLOSE = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       lvl;
   logic       clr;
   logic [3:0] valve_o;
   logic       pump_on_o;
   logic [1:0] grant_id_o;
   logic       busy_o;
   logic       done_o;
   logic       error_o;

   int n_checks = 0;
   int n_errors = 0;

   riego_pump_scheduler #(
      .N_ZONES(N), .OPEN_CYCLES(OPEN), .SLOT_CYCLES(SLOT),
      .CLOSE_CYCLES(CLOSE), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .req_i(req), .level_ok_i(lvl), .fault_clr_i(clr),
      .valve_o(valve_o), .pump_on_o(pump_on_o), .grant_id_o(grant_id_o),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       lvl;
      logic       clr;
      logic [9:0] exp;   // {valve, pump, grant_id, busy, done, error}
   } vec_t;

   vec_t tbl[20];

   function automatic logic [9:0] outs();
      return {valve_o, pump_on_o, grant_id_o, busy_o, done_o, error_o};
   endfunction

   function automatic vec_t mk(input logic [3:0] r, input logic l, input logic c,
                               input logic [3:0] v, input logic p, input logic [1:0] g,
                               input logic b, input logic d, input logic e);
      vec_t x;
      x.req = r; x.lvl = l; x.clr = c; x.exp = {v, p, g, b, d, e};
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
      n_checks++;
      if (got !== need) begin
         n_errors++;
         $display("FAIL %s: got %0h need %0h at %0t", name, got, need, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = '0; lvl = 1'b1; clr = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_pump(input string name);
      int n = 0;
      while (!pump_on_o && n < 50) begin step(); n++; end
      chk(name, {31'd0, pump_on_o}, 32'd1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done_o && n < 50) begin step(); n++; end
      chk(name, {31'd0, done_o}, 32'd1);
   endtask

   // Transaction-level model: a grant is a window of edges counted from the
   // grant edge; pump is on for the RUN length, valve for OPEN+RUN+CLOSE.
   bit m_act, m_flt, m_done;
   int m_zone, m_ptr, m_t, m_run;

   task automatic model_reset();
      m_act = 0; m_flt = 0; m_done = 0; m_zone = 0; m_ptr = 0; m_t = 0; m_run = -1;
   endtask

   task automatic model_step(input logic [3:0] r, input logic l, input logic c);
      bit found;
      m_done = 0;
      if (m_flt) begin
         if (c && l) m_flt = 0;
      end else if (!l) begin
         m_flt = 1;
         m_act = 0;
      end else if (!m_act) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && r[(m_ptr + k) % N]) begin
               found = 1;
               m_zone = (m_ptr + k) % N;
            end
         end
         if (found) begin m_act = 1; m_t = 0; m_run = -1; end
      end else begin
         if (m_run < 0 && m_t >= OPEN && ((m_t - OPEN) == SLOT - 1 || !r[m_zone]))
            m_run = m_t - OPEN + 1;
         if (m_run >= 0 && m_t == OPEN + m_run + CLOSE - 1) begin
            m_act  = 0;
            m_done = 1;
            m_ptr  = (m_zone + 1) % N;
         end else begin
            m_t++;
         end
      end
   endtask

   function automatic logic [9:0] model_outs();
      logic [3:0] v;
      logic       p;
      v = m_act ? 4'(1 << m_zone) : 4'd0;
      p = m_act && m_t >= OPEN && (m_run < 0 || m_t < OPEN + m_run);
      return {v, p, 2'(m_zone), logic'(m_act), logic'(m_done), logic'(m_flt)};
   endfunction

   initial begin
      int gids[5];
      int ng, ndone, nbad, cyc;
      logic [3:0] pv;
      logic pb;

      tbl[0]  = mk(4'b0001, 1, 0, 4'b0001, 0, 0, 1, 0, 0);
      tbl[1]  = mk(4'b0001, 1, 0, 4'b0001, 0, 0, 1, 0, 0);
      for (int i = 2; i <= 9; i++)
         tbl[i] = mk(4'b0001, 1, 0, 4'b0001, 1, 0, 1, 0, 0);
      tbl[10] = mk(4'b0001, 1, 0, 4'b0001, 0, 0, 1, 0, 0);
      tbl[11] = mk(4'b0001, 1, 0, 4'b0001, 0, 0, 1, 0, 0);
      tbl[12] = mk(4'b0000, 1, 0, 4'b0001, 0, 0, 1, 0, 0);
      tbl[13] = mk(4'b0000, 1, 0, 4'b0000, 0, 0, 0, 1, 0);
      tbl[14] = mk(4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
      tbl[15] = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 1);
      tbl[16] = mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0, 0, 1);
      tbl[17] = mk(4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0, 1);
      tbl[18] = mk(4'b0000, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
      tbl[19] = mk(4'b0010, 1, 0, 4'b0010, 0, 1, 1, 0, 0);

      req = '0; lvl = 1'b1; clr = 1'b0; reset = 1'b1;
      #12;
      chk("reset_state", {22'd0, outs()}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single-zone cycle, done pulse, idle fault and clear.
      for (int i = 0; i < 20; i++) begin
         req = tbl[i].req; lvl = tbl[i].lvl; clr = tbl[i].clr;
         step();
         chk($sformatf("table[%0d]", i), {22'd0, outs()}, {22'd0, tbl[i].exp});
      end

      // Round robin with all zones requesting.
      do_reset();
      req = 4'b1111;
      ng = 0; ndone = 0; nbad = 0; cyc = 0;
      pv = '0; pb = 1'b0;
      while (ng < 5 && cyc < 200) begin
         step(); cyc++;
         if ($countones(valve_o) > 1) nbad++;
         if (pv != 0 && valve_o != 0 && pv != valve_o) nbad++;
         if (done_o) ndone++;
         if (busy_o && !pb) begin gids[ng] = grant_id_o; ng++; end
         pv = valve_o; pb = busy_o;
      end
      chk("rr_grants", ng, 5);
      for (int k = 0; k < 5; k++) chk($sformatf("rr_gid[%0d]", k), gids[k], k % 4);
      chk("rr_overlap", nbad, 0);
      chk("rr_done_count", ndone, 4);

      // Early release after three RUN cycles.
      do_reset();
      req = 4'b0100;
      wait_pump("early_pump_rise");
      step(); step();
      req = 4'b0000;
      step();
      chk("early_pump_fall", {27'd0, valve_o, pump_on_o}, {27'd0, 4'b0100, 1'b0});
      step(); step();
      chk("early_valve_held", {28'd0, valve_o}, 32'b0100);
      step();
      chk("early_close", {29'd0, valve_o == 0, busy_o, done_o}, 32'b101);
      req = 4'b1001;
      step();
      chk("early_next_ptr", {30'd0, grant_id_o}, 32'd3);

      // Level fault during RUN, clear handshake, same zone first again.
      do_reset();
      req = 4'b0001;
      wait_pump("fault_pump_rise");
      step(); step(); step();
      lvl = 1'b0;
      step();
      chk("fault_enter", {22'd0, outs()}, {22'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
      clr = 1'b1;
      step();
      chk("fault_clr_only", {31'd0, error_o}, 32'd1);
      lvl = 1'b1; req = 4'b0011;
      step();
      chk("fault_exit", {29'd0, error_o, busy_o, done_o}, 32'd0);
      clr = 1'b0;
      step();
      chk("fault_regrant", {26'd0, valve_o, grant_id_o}, {26'd0, 4'b0001, 2'd0});

      // Level fault on the cycle the slot expires.
      do_reset();
      req = 4'b0001;
      wait_pump("prec_pump_rise");
      repeat (7) step();
      chk("prec_last_run", {31'd0, pump_on_o}, 32'd1);
      lvl = 1'b0;
      step();
      chk("prec_fault", {26'd0, valve_o, busy_o, error_o}, {26'd0, 4'b0000, 1'b0, 1'b1});
      ndone = 0;
      for (int k = 0; k < 4; k++) begin step(); if (done_o) ndone++; end
      chk("prec_no_done", ndone, 0);

      // Asynchronous reset mid-RUN with a nonzero rr pointer beforehand.
      do_reset();
      req = 4'b0100;
      wait_done("rst_first_done");
      wait_pump("rst_pump_rise");
      step(); step();
      #2 reset = 1'b1;
      #1;
      chk("rst_async", {22'd0, outs()}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; req = 4'b1010;
      step();
      chk("rst_ptr_zero", {26'd0, valve_o, grant_id_o}, {26'd0, 4'b0010, 2'd1});

      // Randomized stimulus against the reference model.
      do_reset();
      model_reset();
      nbad = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
         lvl = ($urandom_range(0, 39) != 0);
         clr = ($urandom_range(0, 3) == 0);
         @(posedge clk);
         model_step(req, lvl, clr);
         #1;
         n_checks++;
         if (outs() !== model_outs()) begin
            n_errors++;
            nbad++;
            if (nbad <= 10)
               $display("FAIL random[%0d]: got %b need %b", c, outs(), model_outs());
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
